// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Holds the responder state encoding and the access-fault rule.
package mem_pkg;

    localparam int WORD_W = 32;

    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // A word access faults when it is misaligned or lies beyond the 2**aw word array.
    function automatic logic addr_fault(input logic [WORD_W-1:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 2**AW x 32 data memory with synchronous write and registered read.
// Contents are intentionally never reset.
module dmem_array
    import mem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [2**AW];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one word request,
// waits LATENCY cycles, then pulses a response while stalling the pipeline meanwhile.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    input  logic              i_req_we,
    input  logic [WORD_W-1:0] i_req_addr,
    input  logic [WORD_W-1:0] i_req_wdata,
    output logic              o_req_ready,
    output logic              o_resp_valid,
    output logic [WORD_W-1:0] o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_stall
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_resp_err;
    logic              r_resp_load;

    logic              w_fault;
    logic              w_access;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [WORD_W-1:0] w_rdata;

    assign w_fault  = addr_fault(r_addr, AW);
    assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_mem_we = w_access && r_we && !w_fault;
    assign w_mem_re = w_access && !r_we && !w_fault;

    dmem_array #(.AW(AW)) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (r_addr[AW+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_req_valid) w_next = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request fields are latched only at acceptance so the pipeline may change them during WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_resp_err  <= ERR_NONE;
            r_resp_load <= 1'b0;
        end else if (r_state == IDLE && i_req_valid) begin
            r_cnt   <= CNT_INIT;
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
        end else if (r_state == WAIT) begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_resp_err  <= w_fault ? ERR_ACCESS : ERR_NONE;
                r_resp_load <= !r_we && !w_fault;
            end
        end
    end

    assign o_req_ready  = (r_state == IDLE);
    assign o_resp_valid = (r_state == RESP);
    assign o_resp_err   = (r_state == RESP) && r_resp_err;
    assign o_resp_rdata = ((r_state == RESP) && r_resp_load) ? w_rdata : '0;
    assign o_stall      = rst_n && (((r_state == IDLE) && i_req_valid) || (r_state == WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// requests compared against a word-array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aValid = 1'b0;
    logic        bValid = 1'b0;
    logic        reqWe = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [31:0] reqWdata = '0;

    logic        aReady, aRespValid, aRespErr, aStall;
    logic [31:0] aRespRdata;
    logic        bReady, bRespValid, bRespErr, bStall;
    logic [31:0] bRespRdata;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] mdl [256];
    bit          mdlKnown [256];

    always #5 clk = ~clk;

    dmem_responder #(.AW(8), .LATENCY(2)) dutA (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (aValid),
        .i_req_we     (reqWe),
        .i_req_addr   (reqAddr),
        .i_req_wdata  (reqWdata),
        .o_req_ready  (aReady),
        .o_resp_valid (aRespValid),
        .o_resp_rdata (aRespRdata),
        .o_resp_err   (aRespErr),
        .o_stall      (aStall)
    );

    dmem_responder #(.AW(8), .LATENCY(1)) dutB (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (bValid),
        .i_req_we     (reqWe),
        .i_req_addr   (reqAddr),
        .i_req_wdata  (reqWdata),
        .o_req_ready  (bReady),
        .o_resp_valid (bRespValid),
        .o_resp_rdata (bRespRdata),
        .o_resp_err   (bRespErr),
        .o_stall      (bStall)
    );

    function automatic bit expErr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    // Issues one request to the selected DUT and reports what was observed.
    task automatic doReq(input bit sel, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit scramble,
                         output logic [31:0] rdata, output logic err,
                         output int stallCycles, output int respWait,
                         output bit gotResp, output bit pulseLong, output bit readyAtDrive);
        @(negedge clk);
        reqWe = we; reqAddr = addr; reqWdata = wdata;
        if (sel) bValid = 1'b1; else aValid = 1'b1;
        #1;
        readyAtDrive = sel ? bReady : aReady;
        stallCycles  = (sel ? bStall : aStall) ? 1 : 0;
        @(posedge clk); #1;
        aValid = 1'b0; bValid = 1'b0;
        if (scramble) begin
            reqAddr = $urandom; reqWdata = $urandom; reqWe = ~we;
        end
        gotResp = 1'b0; respWait = 0; rdata = 'x; err = 1'bx; pulseLong = 1'b0;
        for (int k = 1; k <= 20 && !gotResp; k++) begin
            @(negedge clk);
            if (sel ? bStall : aStall) stallCycles++;
            if (sel ? bRespValid : aRespValid) begin
                gotResp = 1'b1; respWait = k;
                rdata = sel ? bRespRdata : aRespRdata;
                err   = sel ? bRespErr : aRespErr;
            end
        end
        @(negedge clk);
        pulseLong = sel ? bRespValid : aRespValid;
    endtask

    task automatic test_reset();
        aValid = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++;
        if (aStall !== 1'b0) begin nFails++; $display("[TB] FAIL reset_stall: got %b expected 0", aStall); end
        nChecks++;
        if ({aRespValid, aRespErr, aRespRdata} !== 34'd0) begin
            nFails++; $display("[TB] FAIL reset_resp: got v=%b e=%b d=%h expected all 0", aRespValid, aRespErr, aRespRdata);
        end
        aValid = 1'b0;
        rst_n  = 1'b1;
        #1;
        nChecks++;
        if (aReady !== 1'b1) begin nFails++; $display("[TB] FAIL reset_ready: got %b expected 1", aReady); end
    endtask

    task automatic test_store_load();
        logic [31:0] d; logic e; int st, rw; bit got, pl, rdy;
        doReq(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, d, e, st, rw, got, pl, rdy);
        mdl[4] = 32'hDEADBEEF; mdlKnown[4] = 1'b1;
        nChecks++;
        if (!got || rdy !== 1'b1) begin nFails++; $display("[TB] FAIL store10_handshake: got resp=%b ready=%b expected 1/1", got, rdy); end
        nChecks++;
        if (st != 3 || rw != 3) begin nFails++; $display("[TB] FAIL store10_timing: got stall=%0d wait=%0d expected 3/3", st, rw); end
        nChecks++;
        if (d !== 32'h0 || e !== 1'b0 || pl !== 1'b0) begin
            nFails++; $display("[TB] FAIL store10_resp: got d=%h e=%b long=%b expected 0/0/0", d, e, pl);
        end
        doReq(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, d, e, st, rw, got, pl, rdy);
        nChecks++;
        if (st != 3 || rw != 3 || !got) begin nFails++; $display("[TB] FAIL load10_timing: got stall=%0d wait=%0d expected 3/3", st, rw); end
        nChecks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0 || pl !== 1'b0) begin
            nFails++; $display("[TB] FAIL load10_data: got d=%h e=%b long=%b expected deadbeef/0/0", d, e, pl);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] d; logic e; int st, rw; bit got, pl, rdy;
        doReq(1'b0, 1'b0, 32'h13, 32'h0, 1'b0, d, e, st, rw, got, pl, rdy);
        nChecks++;
        if (!got || d !== 32'h0 || e !== 1'b1) begin nFails++; $display("[TB] FAIL misaligned_load: got d=%h e=%b expected 0/1", d, e); end
        doReq(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, d, e, st, rw, got, pl, rdy);
        nChecks++;
        if (d !== mdl[4] || e !== 1'b0) begin nFails++; $display("[TB] FAIL after_misaligned: got d=%h e=%b expected %h/0", d, e, mdl[4]); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic e; int st, rw; bit got, pl, rdy;
        doReq(1'b0, 1'b1, 32'h400, 32'h1234, 1'b0, d, e, st, rw, got, pl, rdy);
        nChecks++;
        if (!got || d !== 32'h0 || e !== 1'b1) begin nFails++; $display("[TB] FAIL oor_store: got d=%h e=%b expected 0/1", d, e); end
        for (int w = 0; w < 256; w++) begin
            if (mdlKnown[w]) begin
                doReq(1'b0, 1'b0, 32'(w * 4), 32'h0, 1'b0, d, e, st, rw, got, pl, rdy);
                nChecks++;
                if (d !== mdl[w] || e !== 1'b0) begin
                    nFails++; $display("[TB] FAIL oor_recheck_%0d: got d=%h e=%b expected %h/0", w, d, e, mdl[w]);
                end
            end
        end
    endtask

    task automatic test_capture_hold();
        logic [31:0] d; logic e; int st, rw; bit got, pl, rdy;
        logic [31:0] v;
        v = $urandom;
        doReq(1'b0, 1'b1, 32'h44, v, 1'b1, d, e, st, rw, got, pl, rdy);
        mdl[17] = v; mdlKnown[17] = 1'b1;
        nChecks++;
        if (!got || d !== 32'h0 || e !== 1'b0) begin nFails++; $display("[TB] FAIL hold_store: got d=%h e=%b expected 0/0", d, e); end
        doReq(1'b0, 1'b0, 32'h44, 32'h0, 1'b1, d, e, st, rw, got, pl, rdy);
        nChecks++;
        if (d !== v || e !== 1'b0) begin nFails++; $display("[TB] FAIL hold_load: got d=%h e=%b expected %h/0", d, e, v); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic e; int st, rw; bit got, pl, rdy; bit sawResp;
        doReq(1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, d, e, st, rw, got, pl, rdy);
        mdl[8] = 32'h11111111; mdlKnown[8] = 1'b1;
        @(negedge clk);
        reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'h22222222; aValid = 1'b1;
        @(posedge clk); #1;
        aValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (aStall !== 1'b0 || aRespValid !== 1'b0) begin
            nFails++; $display("[TB] FAIL abort_in_reset: got stall=%b resp=%b expected 0/0", aStall, aRespValid);
        end
        sawResp = 1'b0;
        repeat (2) begin @(negedge clk); if (aRespValid) sawResp = 1'b1; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (aRespValid) sawResp = 1'b1; end
        nChecks++;
        if (sawResp) begin nFails++; $display("[TB] FAIL abort_no_resp: got resp=1 expected 0"); end
        doReq(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, d, e, st, rw, got, pl, rdy);
        nChecks++;
        if (d !== 32'h11111111 || e !== 1'b0) begin nFails++; $display("[TB] FAIL abort_mem: got d=%h e=%b expected 11111111/0", d, e); end
    endtask

    task automatic test_random();
        logic [31:0] d; logic e; int st, rw; bit got, pl, rdy;
        logic [31:0] a, v; bit we, xe;
        int sel;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = 32'($urandom_range(0, 15)) * 4;
            else if (sel == 7) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'd1024 + ($urandom & 32'h00FF_FFFC);
            else               a = 32'($urandom_range(0, 255)) * 4;
            we = $urandom_range(0, 1);
            v  = $urandom;
            xe = expErr(a);
            doReq(1'b0, we, a, v, 1'b1, d, e, st, rw, got, pl, rdy);
            nChecks++;
            if (!got || rw != 3 || e !== xe) begin
                nFails++; $display("[TB] FAIL rand_%0d_resp: addr=%h got resp=%b wait=%0d e=%b expected 1/3/%b", i, a, got, rw, e, xe);
            end
            if (we || xe) begin
                nChecks++;
                if (d !== 32'h0) begin nFails++; $display("[TB] FAIL rand_%0d_zero: got %h expected 0", i, d); end
                if (we && !xe) begin mdl[a / 4] = v; mdlKnown[a / 4] = 1'b1; end
            end else if (mdlKnown[a / 4]) begin
                nChecks++;
                if (d !== mdl[a / 4]) begin nFails++; $display("[TB] FAIL rand_%0d_data: addr=%h got %h expected %h", i, a, d, mdl[a / 4]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; int st, rw; bit got, pl, rdy;
        int accTimes[$];
        int pulses; bit acc, rv, prevRv, overlap;
        logic [31:0] w1, w2;
        w1 = $urandom; w2 = $urandom;
        pulses = 0; prevRv = 1'b0; overlap = 1'b0;
        @(negedge clk);
        reqWe = 1'b1; reqAddr = 32'h0; reqWdata = w1; bValid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            acc = bReady && bValid;
            rv  = bRespValid;
            if (rv) begin pulses++; if (prevRv) overlap = 1'b1; end
            prevRv = rv;
            @(posedge clk); #1;
            if (acc) begin
                accTimes.push_back(c);
                if (accTimes.size() == 1) begin reqAddr = 32'h4; reqWdata = w2; end
                else bValid = 1'b0;
            end
            @(negedge clk);
        end
        bValid = 1'b0;
        nChecks++;
        if (accTimes.size() != 2) begin
            nFails++; $display("[TB] FAIL b2b_accepts: got %0d expected 2", accTimes.size());
        end else begin
            nChecks++;
            if (accTimes[1] - accTimes[0] != 3) begin
                nFails++; $display("[TB] FAIL b2b_interval: got %0d expected 3", accTimes[1] - accTimes[0]);
            end
        end
        nChecks++;
        if (pulses != 2 || overlap) begin nFails++; $display("[TB] FAIL b2b_pulses: got %0d overlap=%b expected 2/0", pulses, overlap); end
        doReq(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, d, e, st, rw, got, pl, rdy);
        nChecks++;
        if (d !== w1 || e !== 1'b0 || st != 2 || rw != 2) begin
            nFails++; $display("[TB] FAIL b2b_load0: got d=%h e=%b stall=%0d wait=%0d expected %h/0/2/2", d, e, st, rw, w1);
        end
        doReq(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, d, e, st, rw, got, pl, rdy);
        nChecks++;
        if (d !== w2 || e !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_load4: got d=%h e=%b expected %h/0", d, e, w2); end
    endtask

    initial begin
        for (int w = 0; w < 256; w++) mdlKnown[w] = 1'b0;
        test_reset();
        test_store_load();
        test_misaligned();
        test_capture_hold();
        test_reset_abort();
        test_random();
        test_out_of_range();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
